// File: rtl/beat_rate_if.sv
// Control and result signals of the beat rate meter, bundled for the datapath.
// The master drives run/flush/beat inputs; the slave (meter) returns the rate.
interface beat_rate_if #(
  parameter int BPM_W = 8
);
  logic             enable;
  logic             clear;
  logic             beat_in;
  logic [BPM_W-1:0] bpm;
  logic             bpm_valid;
  logic             bpm_update;
  logic             bpm_sat;
  logic             beat_seen;

  modport master (
    output enable, clear, beat_in,
    input  bpm, bpm_valid, bpm_update, bpm_sat, beat_seen
  );

  modport slave (
    input  enable, clear, beat_in,
    output bpm, bpm_valid, bpm_update, bpm_sat, beat_seen
  );
endinterface

// File: rtl/beat_rate_meter.sv
// Sliding-window heart-rate meter: qualified beats are counted per segment,
// the last SEGMENTS counts are summed and scaled to beats per minute.
module beat_rate_meter #(
  parameter int SEG_CYCLES     = 100_000_000,
  parameter int SEGMENTS       = 4,
  parameter int SCALE          = 4,
  parameter int REFRACT_CYCLES = 25_000_000,
  parameter int CNT_W          = 6,
  parameter int BPM_W          = 8
) (
  input logic       clk,
  input logic       rst_n,
  beat_rate_if.slave bus
);

  localparam int SUM_W  = CNT_W + $clog2(SEGMENTS);
  localparam int TMR_W  = $clog2(SEG_CYCLES);
  localparam int LCK_W  = $clog2(REFRACT_CYCLES + 1);
  localparam int PTR_W  = $clog2(SEGMENTS);
  localparam int FILL_W = $clog2(SEGMENTS + 1);
  localparam int PROD_W = SUM_W + $clog2(SCALE + 1);
  localparam int CMP_W  = (PROD_W > BPM_W) ? PROD_W : BPM_W + 1;
  localparam logic [CMP_W-1:0] BPM_MAX = {{(CMP_W-BPM_W){1'b0}}, {BPM_W{1'b1}}};

  logic             beat_prev;
  logic [LCK_W-1:0] lockout;
  logic [TMR_W-1:0] timer;
  logic [CNT_W-1:0] seg_cnt;
  logic [CNT_W-1:0] ring [SEGMENTS];
  logic [PTR_W-1:0] wr_ptr;
  logic [SUM_W-1:0] sum;
  logic [FILL_W-1:0] fill;

  logic [BPM_W-1:0] bpm_q;
  logic             bpm_valid_q;
  logic             bpm_update_q;
  logic             bpm_sat_q;
  logic             beat_seen_q;

  logic             beat_edge;
  logic             accept;
  logic             seg_tick;
  logic [CNT_W-1:0] cnt_next;
  logic [SUM_W-1:0] sum_next;
  logic [FILL_W-1:0] fill_next;
  logic [CMP_W-1:0] product;

  always_comb begin
    beat_edge = bus.beat_in & ~beat_prev;
    accept    = bus.enable & beat_edge & (lockout == '0);
    seg_tick  = bus.enable & (timer == TMR_W'(SEG_CYCLES - 1));
    cnt_next  = (accept && (seg_cnt != '1)) ? seg_cnt + CNT_W'(1) : seg_cnt;
    // Sum and bpm are taken from the closing count so a beat accepted on the
    // tick cycle lands in the segment that is closing.
    sum_next  = sum - SUM_W'(ring[wr_ptr]) + SUM_W'(cnt_next);
    fill_next = (fill == FILL_W'(SEGMENTS)) ? fill : fill + FILL_W'(1);
    product   = CMP_W'(sum_next) * CMP_W'(SCALE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_prev    <= 1'b0;
      lockout      <= '0;
      timer        <= '0;
      seg_cnt      <= '0;
      wr_ptr       <= '0;
      sum          <= '0;
      fill         <= '0;
      bpm_q        <= '0;
      bpm_valid_q  <= 1'b0;
      bpm_update_q <= 1'b0;
      bpm_sat_q    <= 1'b0;
      beat_seen_q  <= 1'b0;
      for (int unsigned i = 0; i < SEGMENTS; i++) ring[i] <= '0;
    end else if (bus.clear) begin
      beat_prev    <= 1'b0;
      lockout      <= '0;
      timer        <= '0;
      seg_cnt      <= '0;
      wr_ptr       <= '0;
      sum          <= '0;
      fill         <= '0;
      bpm_q        <= '0;
      bpm_valid_q  <= 1'b0;
      bpm_update_q <= 1'b0;
      bpm_sat_q    <= 1'b0;
      beat_seen_q  <= 1'b0;
      for (int unsigned i = 0; i < SEGMENTS; i++) ring[i] <= '0;
    end else if (bus.enable) begin
      beat_prev    <= bus.beat_in;
      beat_seen_q  <= accept;
      bpm_update_q <= seg_tick;

      if (accept)
        lockout <= LCK_W'(REFRACT_CYCLES);
      else if (lockout != '0)
        lockout <= lockout - LCK_W'(1);

      if (seg_tick) begin
        timer        <= '0;
        seg_cnt      <= '0;
        ring[wr_ptr] <= cnt_next;
        sum          <= sum_next;
        fill         <= fill_next;
        wr_ptr       <= (wr_ptr == PTR_W'(SEGMENTS - 1)) ? '0 : wr_ptr + PTR_W'(1);
        bpm_q        <= (product > BPM_MAX) ? '1 : product[BPM_W-1:0];
        bpm_sat_q    <= (product > BPM_MAX);
        bpm_valid_q  <= (fill_next == FILL_W'(SEGMENTS));
      end else begin
        timer   <= timer + TMR_W'(1);
        seg_cnt <= cnt_next;
      end
    end else begin
      bpm_update_q <= 1'b0;
      beat_seen_q  <= 1'b0;
    end
  end

  assign bus.bpm        = bpm_q;
  assign bus.bpm_valid  = bpm_valid_q;
  assign bus.bpm_update = bpm_update_q;
  assign bus.bpm_sat    = bpm_sat_q;
  assign bus.beat_seen  = beat_seen_q;

endmodule

// File: doc/beat_rate_meter.md
# beat_rate_meter

Parametrised sliding-window heart-rate meter. Qualifies beat pulses from the sensor front end with an edge detector and refractory lockout, counts accepted beats per time segment, keeps a ring buffer of the last SEGMENTS segment counts, and scales the running window sum to beats per minute. It replaces the fixed shift-by-four converter in the health-monitor datapath, feeding the display and alarm logic with a BPM value refreshed every segment rather than once per window.

## Interface
- SEG_CYCLES, 100_000_000: clock cycles per segment (≥2)
- SEGMENTS, 4: segments per window (≥2); window = SEG_CYCLES*SEGMENTS cycles
- SCALE, 4: integer multiplier from window sum to BPM (60 / window seconds)
- REFRACT_CYCLES, 25_000_000: lockout after an accepted beat (≥1)
- CNT_W, 6: per-segment count width; SUM_W = CNT_W + $clog2(SEGMENTS)
- BPM_W, 8: output width
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run; low freezes all state
- clear  in  1  synchronous flush to reset state (priority over enable)
- beat_in  in  1  beat level from front end, already synchronous to clk
- bpm  out  BPM_W  current rate, saturating
- bpm_valid  out  1  high once a full window has been accumulated
- bpm_update  out  1  one-cycle pulse when bpm is rewritten
- bpm_sat  out  1  bpm clamped on last update
- beat_seen  out  1  one-cycle pulse per accepted beat

## Operation
- Edge detect: beat_prev register (reset 0); edge = beat_in & ~beat_prev. beat_prev updates only when enable=1.
- Refractory: lockout counter reset 0. Edge accepted only when enable=1 and lockout==0; acceptance loads REFRACT_CYCLES, which decrements each enabled cycle to 0. Edges during lockout are dropped, not deferred.
- Segment timer: 0..SEG_CYCLES-1, advances when enable=1; seg_tick when timer==SEG_CYCLES-1 and enable=1, timer wraps to 0.
- Segment count: +1 per accepted beat, saturating at 2^CNT_W-1. A beat accepted on the seg_tick cycle belongs to the closing segment.
- On seg_tick: new = closing count (including same-cycle beat); ring[wr_ptr] <= new; sum <= sum - ring[wr_ptr] + new; wr_ptr wraps at SEGMENTS-1; seg count <= 0; fill increments, saturating at SEGMENTS.
- Output stage, cycle after seg_tick: bpm <= min(sum*SCALE, 2^BPM_W-1); bpm_sat <= (sum*SCALE > 2^BPM_W-1); bpm_update pulses; bpm_valid <= (fill==SEGMENTS). Product computed at SUM_W+$clog2(SCALE+1) bits, no wrap.
- enable=0: timer, lockout, counts, ring, beat_prev hold; outputs hold; pulses low.
- clear=1 or rst_n=0: every register to reset value, ring entries to 0.

## Timing
- Reset values: bpm=0, bpm_valid=0, bpm_update=0, bpm_sat=0, beat_seen=0; timer, counts, sum, fill, wr_ptr, lockout=0.
- beat_seen: registered, high the cycle after the accepting edge.
- First seg_tick on the SEG_CYCLES-th enabled cycle after reset; bpm/bpm_update one cycle after each seg_tick.
- bpm_valid rises with the bpm_update following the SEGMENTS-th seg_tick; stays high until reset/clear.
- Before valid, bpm still updates with partial sums.
- rst_n asserted mid-segment: immediate clear, partial segment discarded; first tick after release counts from 0.
- Simultaneous clear and seg_tick: clear wins, no update pulse.
- Max acceptance rate: one beat per REFRACT_CYCLES+1 cycles.

## Test plan
(SEG_CYCLES=10, SEGMENTS=4, SCALE=4, REFRACT_CYCLES=3, CNT_W=6, BPM_W=8 unless noted)
- Reset then idle 100 cycles -> bpm=0, bpm_valid=1 after 4th tick, bpm_sat=0, update pulse every 10 cycles.
- Beat rising edge every 5 cycles -> 2 per segment; after 4th tick bpm=32, bpm_valid=1, beat_seen once per edge.
- Edges 2 cycles apart -> alternate edges dropped by lockout; beat_seen count halves; per-segment count matches accepted only.
- Steady 2/segment then stop -> successive updates 32, 24, 16, 8, 0; bpm_valid stays 1.
- SCALE=30, edge every 4 cycles (seg counts 2–3, sum ≥10) -> bpm=255, bpm_sat=1; removing beats clears bpm_sat when product ≤255.
- enable low 20 cycles mid-segment -> no tick, counts held, next tick delayed 20 cycles; clear or rst_n low mid-window -> all outputs 0, bpm_valid needs 4 new ticks.
